// File: rtl/ofm_pack_writer_if.sv
// rtl/ofm_pack_writer_if.sv - PE result input and OFM BRAM write port bundle
interface ofm_pack_writer_if #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 20
);
    logic [NUM_PE-1:0]   valid;
    logic [NUM_PE*8-1:0] ofm_in;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         wr_data;

    modport master (
        input  valid,
        input  ofm_in,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output valid,
        output ofm_in,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/ofm_pack_writer.sv
// rtl/ofm_pack_writer.sv - packs per-PE OFM bytes into 32-bit BRAM words via a 2-slot ping-pong buffer
// Optional macro RELU_EN clamps negative bytes to zero at capture.
module ofm_pack_writer #(
    parameter int NUM_PE = 16,
    parameter int ADDR_W = 20,
    parameter int PIX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [PIX_W-1:0]  num_pixels,
    ofm_pack_writer_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_partial
);
    localparam int WPP    = NUM_PE / 4;
    localparam int WIDX_W = (WPP > 1) ? $clog2(WPP) : 1;
    localparam int PXW    = NUM_PE * 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [PXW-1:0]    slot_q [2];
    logic [1:0]        full_q, full_d;
    logic              wr_ptr_q, rd_ptr_q;
    logic [WIDX_W-1:0] word_q;
    logic [PIX_W-1:0]  pix_q, num_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              emit, last_word, cap_req, capture, drop, partial;

    function automatic logic [PXW-1:0] relu(input logic [PXW-1:0] px);
        logic [PXW-1:0] r;
        r = px;
`ifdef RELU_EN
        for (int k = 0; k < NUM_PE; k++)
            if (px[8*k+7]) r[8*k +: 8] = 8'h00;
`else
`endif
        return r;
    endfunction

    // Lowest-numbered PE of the group lands in the most significant byte.
    function automatic logic [31:0] pack_word(input logic [PXW-1:0] px, input logic [WIDX_W-1:0] j);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++)
            w[31-8*b -: 8] = px[8*(4*int'(j)+b) +: 8];
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (pix_q == num_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A slot whose last word leaves this edge can take a new pixel on the same edge.
    always_comb begin
        emit      = (state_q == S_RUN) && (pix_q != num_q) && full_q[rd_ptr_q];
        last_word = emit && (word_q == WIDX_W'(WPP - 1));
        cap_req   = (state_q == S_RUN) && (&bus.valid);
        partial   = (state_q == S_RUN) && (|bus.valid) && !(&bus.valid);
        capture   = cap_req && (!(&full_q) || last_word);
        drop      = cap_req && !capture;
        full_d    = full_q;
        if (last_word) full_d[rd_ptr_q] = 1'b0;
        if (capture)   full_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            word_q       <= '0;
            pix_q        <= '0;
            num_q        <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_overflow <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            if (state_q == S_IDLE) begin
                if (start) begin
                    full_q       <= '0;
                    wr_ptr_q     <= 1'b0;
                    rd_ptr_q     <= 1'b0;
                    word_q       <= '0;
                    pix_q        <= '0;
                    num_q        <= num_pixels;
                    addr_q       <= base_addr;
                    err_overflow <= 1'b0;
                    err_partial  <= 1'b0;
                end
            end else begin
                full_q <= full_d;
                if (emit) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr_q;
                    wr_data_q <= pack_word(slot_q[rd_ptr_q], word_q);
                    addr_q    <= addr_q + 1'b1;
                    if (last_word) begin
                        word_q   <= '0;
                        rd_ptr_q <= ~rd_ptr_q;
                        pix_q    <= pix_q + 1'b1;
                    end else begin
                        word_q <= word_q + 1'b1;
                    end
                end
                if (capture) wr_ptr_q <= ~wr_ptr_q;
                if (drop)    err_overflow <= 1'b1;
                if (partial) err_partial  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) slot_q[wr_ptr_q] <= relu(bus.ofm_in);
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_ofm_pack_writer.sv
// tb/tb_ofm_pack_writer.sv - bench for ofm_pack_writer: vector table, corner sequences, random streams vs model
`timescale 1ns/1ps
module tb_ofm_pack_writer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [19:0] base_addr;
    logic [15:0] num_pixels;
    logic        busy, done, err_overflow, err_partial;

    ofm_pack_writer_if #(.NUM_PE(16), .ADDR_W(20)) bus ();

    ofm_pack_writer #(.NUM_PE(16), .ADDR_W(20), .PIX_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_pixels(num_pixels), .bus(bus), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log entries are {edge[11:0], addr, data}; edge is the rising edge that produced the write.
    logic [63:0] wr_log[$];
    logic [63:0] exp_log[$];
    int          done_log[$];
    int          fin_q[$];
    int          idle_dirty = 0;

    always @(negedge clk) begin
        if (bus.wr_en) wr_log.push_back({cyc[11:0], bus.wr_addr, bus.wr_data});
        else if (bus.wr_addr != 20'd0 || bus.wr_data != 32'd0) idle_dirty++;
        if (done) done_log.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [127:0] px, input int k);
        logic [7:0] b;
        b = px[8*k +: 8];
`ifdef RELU_EN
        if ($signed(b) < 0) b = 8'h00;
`endif
        return b;
    endfunction

    // Pixel k occupies the buffer from its capture edge until its last word goes out;
    // the writer serves pixels in order, four consecutive edges each.
    function automatic bit model_offer(input int t, input logic [127:0] px, input logic [19:0] base);
        int held, s, k;
        held = 0;
        foreach (fin_q[i]) if (fin_q[i] > t) held++;
        if (held >= 2) return 1'b0;
        s = t + 1;
        if (fin_q.size() > 0 && fin_q[$] + 1 > s) s = fin_q[$] + 1;
        k = fin_q.size();
        for (int j = 0; j < 4; j++) begin
            logic [31:0] w;
            logic [19:0] a;
            w = {ref_byte(px, 4*j), ref_byte(px, 4*j+1), ref_byte(px, 4*j+2), ref_byte(px, 4*j+3)};
            a = base + 20'(4*k + j);
            exp_log.push_back({12'(s + j), a, w});
        end
        fin_q.push_back(s + 3);
        return 1'b1;
    endfunction

    task automatic clear_logs();
        wr_log.delete(); done_log.delete(); exp_log.delete(); fin_q.delete();
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_log.size() == 0 && n < limit) begin tick(); n++; end
        tick(); tick();
    endtask

    task automatic pulse_start(input logic [19:0] base, input int num);
        base_addr = base; num_pixels = 16'(num); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_stream(input logic [19:0] base, input int num, input int mode, input string tag);
        int s_edge, t, guard;
        bit ovf, part;
        logic [127:0] px;
        ovf = 1'b0; part = 1'b0; guard = 0;
        clear_logs();
        s_edge = cyc + 1;
        pulse_start(base, num);
        while (fin_q.size() < num && guard < 30000) begin
            t = cyc + 1;
            px = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.ofm_in = px;
            bus.valid  = '0;
            if (mode == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 4)       bus.valid = '1;
                else if (r == 4) bus.valid = 16'($urandom_range(1, 32'hFFFE));
            end else if ((t - s_edge) % 36 == 1) begin
                bus.valid = '1;
            end
            if (&bus.valid) begin
                if (!model_offer(t, px, base)) ovf = 1'b1;
            end else if (bus.valid != '0) begin
                part = 1'b1;
            end
            tick();
            guard++;
        end
        bus.valid = '0;
        check({tag, "_stim_bound"}, 64'(guard < 30000), 64'd1);
        wait_done(2000);
        check({tag, "_count"}, 64'(wr_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
            check({tag, "_wr"}, wr_log[i], exp_log[i]);
        check({tag, "_done"}, 64'(done_log.size() == 1 ? done_log[0] : -1),
              64'(fin_q.size() > 0 ? fin_q[$] + 1 : 0));
        check({tag, "_flags"}, {62'd0, err_overflow, err_partial}, {62'd0, ovf, part});
        check({tag, "_idle"}, {62'd0, busy, bus.wr_en}, 64'd0);
    endtask

    typedef struct {
        logic [127:0]     ofm;
        logic [19:0]      base;
        logic [3:0][19:0] addr;
        logic [3:0][31:0] word;
    } vec_t;
    vec_t tab[3];

    initial begin
        int t;
        logic [127:0] px;

        tab[0].ofm  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        tab[0].base = 20'h00000;
        tab[0].addr = {20'h00003, 20'h00002, 20'h00001, 20'h00000};
        tab[0].word = {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
        tab[1].ofm  = 128'h00000000_00000000_00000000_01FF7F80;
        tab[1].base = 20'h00100;
        tab[1].addr = {20'h00103, 20'h00102, 20'h00101, 20'h00100};
        tab[2].ofm  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        tab[2].base = 20'hFFFFE;
        tab[2].addr = {20'h00001, 20'h00000, 20'hFFFFF, 20'hFFFFE};
`ifdef RELU_EN
        tab[1].word = {32'h00000000, 32'h00000000, 32'h00000000, 32'h007F0001};
        tab[2].word = {32'h33221100, 32'h77665544, 32'h00000000, 32'h00000000};
`else
        tab[1].word = {32'h00000000, 32'h00000000, 32'h00000000, 32'h807FFF01};
        tab[2].word = {32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
`endif

        reset = 1'b1; start = 1'b0; base_addr = '0; num_pixels = '0;
        bus.valid = '0; bus.ofm_in = '0;
        tick(); tick(); tick();
        check("reset_outputs", {25'd0, busy, done, err_overflow, err_partial, bus.wr_en, bus.wr_addr, bus.wr_data}, 64'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) begin
            clear_logs();
            pulse_start(tab[v].base, 1);
            t = cyc + 1;
            bus.valid = '1; bus.ofm_in = tab[v].ofm;
            tick();
            bus.valid = '0;
            wait_done(20);
            check("tab_count", 64'(wr_log.size()), 64'd4);
            for (int j = 0; j < 4 && j < wr_log.size(); j++)
                check("tab_wr", wr_log[j], {12'(t + 1 + j), tab[v].addr[j], tab[v].word[j]});
            check("tab_done", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'(t + 5));
        end

        // zero pixels: done on the edge after start, nothing written
        clear_logs();
        t = cyc + 1;
        pulse_start(20'h00123, 0);
        wait_done(10);
        check("zero_writes", 64'(wr_log.size()), 64'd0);
        check("zero_done", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'(t + 1));

        // three back-to-back pixels: third dropped; start while busy ignored
        clear_logs();
        pulse_start(20'h00040, 2);
        t = cyc + 1;
        bus.valid = '1;
        for (int p = 0; p < 3; p++) begin
            bus.ofm_in = {4{$urandom()}};
            if (p == 1) begin start = 1'b1; base_addr = 20'h00999; num_pixels = 16'd5; end
            tick();
            start = 1'b0;
        end
        bus.valid = '0;
        wait_done(40);
        check("ovf_count", 64'(wr_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++)
            check("ovf_addr", 64'(wr_log[i][51:32]), 64'(20'h00040 + 20'(i)));
        check("ovf_flag", {62'd0, err_overflow, err_partial}, 64'd2);
        check("ovf_done", 64'(done_log.size() == 1 ? done_log[0] : -1), 64'(t + 9));

        // partial valid sets err_partial, only the full pixel is written; start clears flags
        clear_logs();
        pulse_start(20'h00200, 1);
        check("flags_cleared", {62'd0, err_overflow, busy}, 64'd1);
        t = cyc + 1;
        bus.valid = 16'h00FF; bus.ofm_in = 128'hDEAD;
        tick();
        bus.valid = '1; bus.ofm_in = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        tick();
        bus.valid = '0;
        wait_done(20);
        check("part_count", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() > 0)
            check("part_first", wr_log[0], {12'(t + 2), 20'h00200, 32'h00010203});
        check("part_flag", {62'd0, err_overflow, err_partial}, 64'd1);

        // reset during pixel 2 word 1 aborts without further writes or done
        clear_logs();
        pulse_start(20'h00000, 3);
        t = cyc + 1;
        bus.valid = '1; bus.ofm_in = {4{$urandom()}};
        tick(); tick();
        bus.valid = '0;
        while (cyc < t + 6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("rst_writes", 64'(wr_log.size()), 64'd6);
        check("rst_state", {61'd0, busy, bus.wr_en, 1'b0}, 64'd0);
        check("rst_no_done", 64'(done_log.size()), 64'd0);

        run_stream(20'($urandom()), 40, 0, "rand_a");
        run_stream(20'hFFFF0, 25, 0, "rand_wrap");
        run_stream(20'h00000, 150, 1, "rate36");

        px = '0;
        check("idle_bus_zero", 64'(idle_dirty), 64'(px[31:0]));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
